// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM states, default width and
// the half-subtractor primitive used to build the full-subtractor bit cell.
package serial_sub_pkg;

    localparam int SERIAL_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic d;
        logic bout;
    } hsub_t;

    function automatic hsub_t half_sub(input logic x, input logic y);
        hsub_t r;
        r.d    = x ^ y;
        r.bout = ~x & y;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational full-subtractor bit cell: two cascaded half-subtractors whose
// borrows are OR'ed (d = a ^ b ^ bin, bout = ~a&b | ~(a^b)&bin).
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    hsub_t w_s1;
    hsub_t w_s2;

    assign w_s1 = half_sub(a, b);
    assign w_s2 = half_sub(w_s1.d, bin);
    assign d    = w_s2.d;
    assign bout = w_s1.bout | w_s2.bout;

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor (a - b), one bit per clock, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_work;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_work_next;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last      = (r_cnt == LAST_BIT);
    // New bit enters at the MSB; bit 0 of this vector only matters on the final step.
    assign w_work_next = {w_d, r_work};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_work <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_bin <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_work <= w_work_next[WIDTH-1:1];
                    if (w_last) begin
                        diff   <= w_work_next;
                        borrow <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last step r_a[0]/r_b[0] hold the original sign bits.
                        ovf    <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes model results, a
// monitor pops and compares on every done pulse (including its cycle).
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    int           n_pass = 0;
    int           n_total = 0;
    int           cyc = 0;
    logic [W-1:0] held_diff = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        exp_t e;
        int ua, ub, sa, sb, r;
        ua = int'(ta);
        ub = int'(tb_);
        sa = $signed(ta);
        sb = $signed(tb_);
        r  = sa - sb;
        e.diff   = W'(ua - ub);
        e.borrow = (ua < ub);
        e.ovf    = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        e.cyc    = 0;
        return e;
    endfunction

    // Monitor: one scoreboard entry per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                m_e = q.pop_front();
                check("diff", diff, m_e.diff);
                check("borrow", borrow, m_e.borrow);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", ovf, m_e.ovf);
`endif
                check("done_cycle", cyc, m_e.cyc);
                check("busy_at_done", busy, 1);
                held_diff = m_e.diff;
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        exp_t e;
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("issue_timeout_busy", busy, 0);
        e     = model(ta, tb_);
        e.cyc = cyc + 1 + W;
        a     = ta;
        b     = tb_;
        start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("drain_timeout_pending", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [W-1:0] ha[3];
        logic [W-1:0] hb[3];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands, including sign/overflow boundaries
        issue(8'd200, 8'd55);
        issue(8'd5, 8'd9);
        issue(8'h80, 8'h80);
        issue(8'h80, 8'h01);
        issue(8'h10, 8'h01);
        issue(8'h7F, 8'hFF);
        drain();

        // start pulsed mid-RUN is ignored; diff holds until completion
        issue(8'd10, 8'd4);
        repeat (3) @(negedge clk);
        check("diff_hold_mid_run", diff, held_diff);
        a = 8'd3;
        b = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_run", busy, 1);
        check("diff_hold_late", diff, held_diff);
        drain();
        check("diff_after_ignored_start", diff, 8'd6);

        // Asynchronous reset during bit 4 abandons the op
        issue(8'd100, 8'd1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        issue(8'd100, 8'd1);
        drain();

        // start held high: back-to-back ops every WIDTH+2 cycles
        ha[0] = 8'hFF; hb[0] = 8'h00;
        ha[1] = 8'h00; hb[1] = 8'hFF;
        ha[2] = 8'h0F; hb[2] = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            a = ha[k];
            b = hb[k];
            e = model(ha[k], hb[k]);
            e.cyc = cyc + 1 + W;
            q.push_back(e);
            start = 1'b1;
            @(posedge clk);
            if (k < 2) begin
                repeat (W + 1) @(posedge clk);
                @(negedge clk);
            end
        end
        #1 start = 1'b0;
        drain();

        // Randomized operands with random idle gaps
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
